// File: rtl/uart_pkt_arbiter_if.sv
`timescale 1ns/1ps
// Requester, status and UART-side signals of uart_pkt_arbiter.
// master = arbiter side, slave = requesters plus the UART.
interface uart_pkt_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_i;
    logic [32*NUM_REQ-1:0] data_i;
    logic [NUM_REQ-1:0]    ack_o;
    logic                  err_o;
    logic                  busy_o;
    logic                  uart_wr_o;
    logic [7:0]            uart_dat_o;
    logic                  uart_busy_i;

    modport master (
        input  req_i, data_i, uart_busy_i,
        output ack_o, err_o, busy_o, uart_wr_o, uart_dat_o
    );

    modport slave (
        output req_i, data_i, uart_busy_i,
        input  ack_o, err_o, busy_o, uart_wr_o, uart_dat_o
    );
endinterface

// File: rtl/uart_pkt_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one byte-wide UART transmitter between NUM_REQ
// requesters; each 32-bit word goes out as a 7-byte sync/id/data/checksum packet.
module uart_pkt_arbiter #(
    parameter int         NUM_REQ   = 4,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         WAIT_MAX  = 15
) (
    input  logic               sys_clk_i,
    input  logic               sys_rst_n_i,
    uart_pkt_arbiter_if.master bus
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WDW = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_HI, DONE} state_e;

    state_e             state_q;
    logic [IDW-1:0]     rr_q;
    logic [IDW-1:0]     gnt_q;
    logic [2:0]         cnt_q;
    logic [WDW-1:0]     wd_q;
    logic [31:0]        word_q;
    logic [NUM_REQ-1:0] ack_q;
    logic               err_q;
    logic               busy_q;
    logic [7:0]         dat_q;

    logic               pick_vld_d;
    logic [IDW-1:0]     pick_d;
    logic [31:0]        pick_word_d;

    function automatic logic [7:0] pkt_byte(input logic [2:0] idx,
                                            input logic [IDW-1:0] id,
                                            input logic [31:0] w);
        logic [7:0] idb;
        idb = 8'(id);
        case (idx)
            3'd0:    pkt_byte = SYNC_BYTE;
            3'd1:    pkt_byte = idb;
            3'd2:    pkt_byte = w[31:24];
            3'd3:    pkt_byte = w[23:16];
            3'd4:    pkt_byte = w[15:8];
            3'd5:    pkt_byte = w[7:0];
            default: pkt_byte = idb ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        endcase
    endfunction

    // Walk offsets downward so the smallest offset from the pointer wins.
    always_comb begin
        int j;
        pick_vld_d  = 1'b0;
        pick_d      = '0;
        pick_word_d = '0;
        j           = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(rr_q) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (bus.req_i[j]) begin
                pick_vld_d  = 1'b1;
                pick_d      = IDW'(j);
                pick_word_d = bus.data_i[32*j +: 32];
            end
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            state_q <= IDLE;
            rr_q    <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            wd_q    <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            dat_q   <= '0;
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_vld_d) begin
                        gnt_q   <= pick_d;
                        cnt_q   <= '0;
                        dat_q   <= SYNC_BYTE;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (!bus.uart_busy_i) begin
                        wd_q    <= '0;
                        state_q <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (bus.uart_busy_i) begin
                        if (cnt_q == 3'd6) begin
                            ack_q   <= NUM_REQ'(1) << gnt_q;
                            state_q <= DONE;
                        end else begin
                            cnt_q   <= cnt_q + 3'd1;
                            dat_q   <= pkt_byte(cnt_q + 3'd1, gnt_q, word_q);
                            state_q <= LOAD;
                        end
                    end else if (wd_q == WDW'(WAIT_MAX - 1)) begin
                        // UART never took the byte: abandon the packet but still ack it.
                        err_q   <= 1'b1;
                        ack_q   <= NUM_REQ'(1) << gnt_q;
                        state_q <= DONE;
                    end else begin
                        wd_q <= wd_q + WDW'(1);
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    rr_q    <= (gnt_q == IDW'(NUM_REQ - 1)) ? '0 : gnt_q + IDW'(1);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Granted word is pure datapath; it is only read while a packet is in flight.
    always_ff @(posedge sys_clk_i) begin
        if (state_q == IDLE && pick_vld_d) word_q <= pick_word_d;
    end

    assign bus.uart_wr_o  = (state_q == LOAD) && !bus.uart_busy_i;
    assign bus.uart_dat_o = dat_q;
    assign bus.ack_o      = ack_q;
    assign bus.err_o      = err_q;
    assign bus.busy_o     = busy_q;
endmodule

// File: tb/tb_uart_pkt_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for uart_pkt_arbiter: UART and requester models plus a
// packet-level reference model of grant order, packet bytes and ack timing.
module tb_uart_pkt_arbiter;
    localparam int         N    = 4;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         WMAX = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_pkt_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_pkt_arbiter #(.NUM_REQ(N), .SYNC_BYTE(SYNC), .WAIT_MAX(WMAX)) dut (
        .sys_clk_i  (clk),
        .sys_rst_n_i(rst_n),
        .bus        (bus)
    );

    always #52 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int          cyc = 0, pkt_cnt = 0, wr_total = 0, last_wr_cyc = 0, rr_m = 0;
    int          exp_id_q[$];
    logic [31:0] exp_w_q[$];
    logic [7:0]  bq[$];
    int          ids_log[$];
    logic [7:0]  last_pkt[7];
    int          req_mode = 0;
    bit          wd_mode = 0, err_exp = 0;
    bit          force_busy = 0, no_busy = 0, accept_pend = 0, blen_rand = 0;
    int          busy_cnt = 0;
    logic [N-1:0]    req_snap = '0;
    logic [32*N-1:0] data_snap = '0;
    bit          prev_busy = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int i = 0; i < N; i++) if (m[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    function automatic logic [7:0] exp_byte(input int i, input int id, input logic [31:0] w);
        logic [7:0] b[7];
        b[0] = SYNC;
        b[1] = 8'(id);
        for (int k = 0; k < 4; k++) b[2+k] = 8'((w >> (24 - 8 * k)) & 32'hFF);
        b[6] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
        return b[i];
    endfunction

    // UART: raises busy the cycle after accepting a byte, for a number of bit-times.
    initial begin
        bus.uart_busy_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (accept_pend) begin
                accept_pend = 0;
                if (!no_busy) busy_cnt = blen_rand ? int'($urandom_range(1, 12)) : 11;
            end
            bus.uart_busy_i = force_busy || (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt--;
        end
    end

    task automatic handle_ack();
        int k, eid;
        logic [31:0] ew;
        chk("ack_onehot", $countones(bus.ack_o), 1);
        k = 0;
        for (int i = 0; i < N; i++) if (bus.ack_o[i]) k = i;
        chk("ack_has_grant", (exp_id_q.size() > 0) ? 1 : 0, 1);
        eid = -1;
        ew  = '0;
        if (exp_id_q.size() > 0) begin
            eid = exp_id_q.pop_front();
            ew  = exp_w_q.pop_front();
        end
        chk("ack_id", k, eid);
        if (wd_mode) begin
            chk("wd_bytes", bq.size(), 1);
            if (bq.size() > 0) chk("wd_byte0", bq[0], SYNC);
            chk("wd_latency", cyc - last_wr_cyc, WMAX + 1);
            chk("wd_err", bus.err_o, 1);
        end else begin
            chk("pkt_len", bq.size(), 7);
            if (bq.size() == 7)
                for (int i = 0; i < 7; i++) chk("pkt_byte", bq[i], exp_byte(i, eid, ew));
            chk("ack_latency", cyc - last_wr_cyc, 2);
            chk("err_level", bus.err_o, err_exp);
        end
        for (int i = 0; i < 7; i++) last_pkt[i] = (i < bq.size()) ? bq[i] : 8'h00;
        ids_log.push_back(k);
        bq.delete();
        pkt_cnt++;
        rr_m = (k + 1) % N;
        case (req_mode)
            0: bus.req_i[k] = 1'b0;
            1: bus.data_i[32*k +: 32] = $urandom;
            default: begin
                if ($urandom_range(0, 1) == 1) bus.req_i[k] = 1'b0;
                bus.data_i[32*k +: 32] = $urandom;
                bus.req_i = bus.req_i | N'($urandom_range(0, (1 << N) - 1));
                if (bus.req_i == '0) bus.req_i[$urandom_range(0, N - 1)] = 1'b1;
            end
        endcase
    endtask

    // Monitor and reference model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                bq.delete();
                exp_id_q.delete();
                exp_w_q.delete();
                rr_m      = 0;
                prev_busy = 0;
            end else begin
                if (!prev_busy && bus.busy_o) begin
                    int g;
                    g = pick(req_snap, rr_m);
                    chk("grant_has_req", (g >= 0) ? 1 : 0, 1);
                    exp_id_q.push_back(g);
                    exp_w_q.push_back((g >= 0) ? data_snap[32*((g >= 0) ? g : 0) +: 32] : 32'h0);
                end
                prev_busy = bus.busy_o;
                if (bus.uart_wr_o) begin
                    chk("wr_while_busy", bus.uart_busy_i, 0);
                    bq.push_back(bus.uart_dat_o);
                    last_wr_cyc = cyc;
                    accept_pend = 1;
                    wr_total++;
                end
                if (bus.ack_o != '0) handle_ack();
            end
            req_snap  = bus.req_i;
            data_snap = bus.data_i;
        end
    end

    task automatic wait_pkts(input int target, input int budget, input string tag);
        int c;
        c = 0;
        while (pkt_cnt < target && c < budget) begin
            @(posedge clk);
            c++;
        end
        chk(tag, (pkt_cnt >= target) ? 1 : 0, 1);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while (bus.busy_o && c < 400) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk(tag, bus.busy_o, 0);
    endtask

    task automatic wait_busy(input string tag);
        int c;
        c = 0;
        while (!bus.busy_o && c < 50) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk(tag, bus.busy_o, 1);
    endtask

    initial begin
        logic [7:0] exp1[7];
        int base, w0, c;
        exp1 = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0A};
        bus.req_i  = '0;
        bus.data_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", bus.ack_o, 0);
        chk("rst_err", bus.err_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_wr", bus.uart_wr_o, 0);
        chk("rst_dat", bus.uart_dat_o, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_no_req", bus.busy_o, 0);

        // Single request from requester 2.
        base = pkt_cnt;
        w0   = wr_total;
        bus.data_i[95:64] = 32'h12345678;
        bus.req_i = 4'b0100;
        wait_pkts(base + 1, 400, "t1_timeout");
        for (int i = 0; i < 7; i++) chk("t1_byte", last_pkt[i], exp1[i]);
        chk("t1_wr_count", wr_total - w0, 7);
        chk("t1_ack_id", ids_log[$], 2);
        chk("t1_err", bus.err_o, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("t1_single_ack", pkt_cnt, base + 1);

        // All four requesting continuously from reset.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ids_log.delete();
        for (int k = 0; k < N; k++) bus.data_i[32*k +: 32] = $urandom;
        req_mode  = 1;
        base      = pkt_cnt;
        bus.req_i = '1;
        wait_pkts(base + 8, 2000, "t2_timeout");
        bus.req_i = '0;
        req_mode  = 0;
        for (int i = 0; i < 8; i++) chk("t2_order", (i < ids_log.size()) ? ids_log[i] : -1, i % N);
        wait_idle("t2_idle");

        // Fairness: 1 served, then 1 and 3 both pending -> 3 before 1.
        ids_log.delete();
        req_mode  = 1;
        base      = pkt_cnt;
        bus.req_i = 4'b0010;
        wait_busy("t3_grant");
        bus.req_i = 4'b1010;
        wait_pkts(base + 3, 600, "t3_timeout");
        bus.req_i = '0;
        req_mode  = 0;
        chk("t3_first", (ids_log.size() > 0) ? ids_log[0] : -1, 1);
        chk("t3_second", (ids_log.size() > 1) ? ids_log[1] : -1, 3);
        chk("t3_third", (ids_log.size() > 2) ? ids_log[2] : -1, 1);
        wait_idle("t3_idle");

        // Randomized requests, words and UART byte times.
        blen_rand = 1;
        req_mode  = 2;
        base      = pkt_cnt;
        for (int k = 0; k < N; k++) bus.data_i[32*k +: 32] = $urandom;
        bus.req_i = N'($urandom_range(1, (1 << N) - 1));
        wait_pkts(base + 16, 4000, "t4_timeout");
        bus.req_i = '0;
        req_mode  = 0;
        wait_idle("t4_idle");
        blen_rand = 0;

        // Backpressure on the first byte.
        force_busy = 1;
        repeat (2) @(posedge clk);
        #1;
        base = pkt_cnt;
        bus.data_i[31:0] = $urandom;
        bus.req_i = 4'b0001;
        wait_busy("t5_grant");
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("bp_no_wr", bus.uart_wr_o, 0);
            chk("bp_dat", bus.uart_dat_o, SYNC);
        end
        force_busy = 0;
        @(negedge clk);
        chk("bp_wr_fires", bus.uart_wr_o, 1);
        chk("bp_dat_fire", bus.uart_dat_o, SYNC);
        wait_pkts(base + 1, 400, "t5_timeout");
        wait_idle("t5_idle");

        // Watchdog: UART never raises busy.
        no_busy   = 1;
        wd_mode   = 1;
        base      = pkt_cnt;
        bus.req_i = 4'b0001;
        wait_pkts(base + 1, 200, "t6_timeout");
        chk("t6_err", bus.err_o, 1);
        no_busy = 0;
        wd_mode = 0;
        err_exp = 1;
        wait_idle("t6_idle");
        bus.data_i[95:64] = $urandom;
        bus.req_i = 4'b0100;
        wait_pkts(base + 2, 400, "t6_next_timeout");
        chk("t6_next_id", ids_log[$], 2);
        chk("t6_err_sticky", bus.err_o, 1);
        wait_idle("t6_next_idle");

        // Async reset at the third byte of a packet from requester 1.
        base = pkt_cnt;
        bus.data_i[63:32]  = $urandom;
        bus.data_i[127:96] = $urandom;
        bus.req_i = 4'b0010;
        c = 0;
        while (bq.size() < 3 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("t7_reach_byte3", (bq.size() >= 3) ? 1 : 0, 1);
        bus.req_i = 4'b1010;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_ack", bus.ack_o, 0);
        chk("ar_err", bus.err_o, 0);
        chk("ar_busy", bus.busy_o, 0);
        chk("ar_wr", bus.uart_wr_o, 0);
        chk("ar_dat", bus.uart_dat_o, 0);
        err_exp = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("ar_no_ack", pkt_cnt, base);
        rst_n = 1'b1;
        ids_log.delete();
        wait_pkts(base + 2, 800, "t7_timeout");
        chk("ar_first_id", (ids_log.size() > 0) ? ids_log[0] : -1, 1);
        chk("ar_second_id", (ids_log.size() > 1) ? ids_log[1] : -1, 3);
        chk("ar_sync", last_pkt[0], SYNC);
        wait_idle("t7_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
